// File: rtl/gray_seq_pkg.sv
// Shared types, default widths and Gray conversion helper for the Gray sequencing arbiter.
package gray_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int unsigned W_DEF     = 3;
    localparam int unsigned LEN_W_DEF = 4;

    // Bit i of the binary value is the XOR of all Gray bits at position i and above.
    function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_seq_arbiter_gray_next.sv
// Combinational W-bit Gray successor: Gray -> binary, +1 mod 2^W, binary -> Gray.
module gray_next
    import gray_seq_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic [W-1:0] gray_in,
    output logic [W-1:0] gray_out
);

    logic [W-1:0] bin;
    logic [W-1:0] bin_inc;

    always_comb begin
        bin      = W'(gray_to_bin(32'(gray_in)));
        bin_inc  = bin + W'(1);
        gray_out = bin_inc ^ (bin_inc >> 1);
    end

endmodule

// File: rtl/gray_seq_arbiter.sv
// Round-robin arbiter that loads and steps the shared Gray counter for two requesters,
// reporting completion, abort and wrap-around.
module gray_seq_arbiter
    import gray_seq_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [W-1:0]     start0,
    input  logic [W-1:0]     start1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [W-1:0]     gray,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             wrap
);

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic             ptr;
    logic             owner;
    logic             win_sel;
    logic             owner_req;
    logic [W-1:0]     sel_start;
    logic [LEN_W-1:0] sel_len;
    logic [W-1:0]     gray_step;

    // win_sel = 1 selects requester 1; the pointer's favourite wins only if it is asking.
    always_comb begin
        win_sel   = ptr ? req1 : ~req0;
        sel_start = win_sel ? start1 : start0;
        sel_len   = win_sel ? len1 : len0;
        owner_req = owner ? req1 : req0;
    end

    assign busy = (state != IDLE);

    gray_next #(.W(W)) u_gray_next (
        .gray_in  (gray),
        .gray_out (gray_step)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gray    <= '0;
            rem     <= '0;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner <= win_sel;
                        gnt0  <= ~win_sel;
                        gnt1  <= win_sel;
                        gray  <= sel_start;
                        rem   <= sel_len;
                        ptr   <= ~win_sel;
                        if (sel_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (owner_req) begin
                        gray <= gray_step;
                        rem  <= rem - LEN_W'(1);
                        wrap <= (gray_step == '0);
                        if (rem == LEN_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        state   <= DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end
                end
                DONE: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    done    <= 1'b0;
                    aborted <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_seq_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a binary-index reference model.
module tb_gray_seq_arbiter;

    localparam int W     = 3;
    localparam int LEN_W = 4;
    localparam int N     = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             req0, req1;
    logic [W-1:0]     start0, start1;
    logic [LEN_W-1:0] len0, len1;
    logic             gnt0, gnt1, busy, done, aborted, wrap;
    logic [W-1:0]     gray;

    gray_seq_arbiter #(.W(W), .LEN_W(LEN_W)) dut (
        .clock   (clock),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .start0  (start0),
        .start1  (start1),
        .len0    (len0),
        .len1    (len1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gray    (gray),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .wrap    (wrap)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Position of a code in the Gray sequence, found by searching the sequence itself.
    function automatic int gray_index(input int g);
        for (int i = 0; i < N; i++) begin
            if (((i ^ (i >> 1)) % N) == g) return i;
        end
        return 0;
    endfunction

    // Reference model: the counter is tracked as a plain position in the Gray sequence.
    int m_state, m_bin, m_rem, m_win, m_ptr;
    bit m_gnt0, m_gnt1, m_done, m_ab, m_wrap;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state = 0; m_bin = 0; m_rem = 0; m_win = 0; m_ptr = 0;
            m_gnt0 = 0; m_gnt1 = 0; m_done = 0; m_ab = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (m_state == 0) begin
                if (req0 || req1) begin
                    if (m_ptr == 0) m_win = req0 ? 0 : 1;
                    else            m_win = req1 ? 1 : 0;
                    m_gnt0 = (m_win == 0);
                    m_gnt1 = (m_win == 1);
                    m_bin  = gray_index(m_win ? int'(start1) : int'(start0));
                    m_rem  = m_win ? int'(len1) : int'(len0);
                    m_ptr  = 1 - m_win;
                    if (m_rem == 0) begin m_state = 2; m_done = 1; end
                    else m_state = 1;
                end
            end else if (m_state == 1) begin
                if ((m_win == 0) ? req0 : req1) begin
                    m_bin  = (m_bin + 1) % N;
                    m_rem  = m_rem - 1;
                    m_wrap = (m_bin == 0);
                    if (m_rem == 0) begin m_state = 2; m_done = 1; end
                end else begin
                    m_state = 2; m_done = 1; m_ab = 1;
                end
            end else begin
                m_gnt0 = 0; m_gnt1 = 0; m_done = 0; m_ab = 0; m_state = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en && !reset) begin
            chk("m_gnt0",    gnt0,    m_gnt0);
            chk("m_gnt1",    gnt1,    m_gnt1);
            chk("m_gray",    gray,    (m_bin ^ (m_bin >> 1)) % N);
            chk("m_busy",    busy,    m_state != 0);
            chk("m_done",    done,    m_done);
            chk("m_aborted", aborted, m_ab);
            chk("m_wrap",    wrap,    m_wrap);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    int rr_exp [12] = '{1, 1, 1, 0, 2, 2, 2, 0, 1, 1, 1, 0};
    int full_seq [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
    int wraps;
    int n_done;

    initial begin
        reset = 1'b0;
        req0 = 0; req1 = 0; start0 = '0; start1 = '0; len0 = '0; len1 = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        cmp_en = 1'b1;

        @(negedge clock);
        chk("rst_gray", gray, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_busy", busy, 0);

        // Single run with wrap
        req0 = 1; start0 = 3'b100; len0 = 4'd3;
        @(negedge clock); chk("t1_gnt0", gnt0, 1); chk("t1_gray0", gray, 3'b100);
        @(negedge clock); chk("t1_gray1", gray, 3'b000); chk("t1_wrap", wrap, 1);
        @(negedge clock); chk("t1_gray2", gray, 3'b001); chk("t1_wrap_off", wrap, 0);
        @(negedge clock); chk("t1_gray3", gray, 3'b011); chk("t1_done", done, 1);
        chk("t1_done_gnt", gnt0, 1); chk("t1_abort", aborted, 0);
        req0 = 0;
        @(negedge clock); chk("t1_idle", busy, 0); chk("t1_gnt_drop", gnt0, 0);

        // Contention and round-robin from reset
        do_reset();
        req0 = 1; req1 = 1; len0 = 4'd2; len1 = 4'd2; start0 = 3'b000; start1 = 3'b101;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            chk($sformatf("rr_gnt_c%0d", c), {gnt1, gnt0}, rr_exp[c]);
        end
        req0 = 0; req1 = 0;
        @(negedge clock);

        // Zero-length run
        req1 = 1; start1 = 3'b110; len1 = 4'd0;
        @(negedge clock);
        chk("z_gnt1", gnt1, 1); chk("z_done", done, 1); chk("z_gray", gray, 3'b110); chk("z_wrap", wrap, 0);
        req1 = 0;
        @(negedge clock);
        chk("z_gnt_drop", gnt1, 0); chk("z_done_drop", done, 0); chk("z_gray_hold", gray, 3'b110);

        // Abort after two steps
        req0 = 1; start0 = 3'b000; len0 = 4'd5;
        @(negedge clock); chk("ab_gray0", gray, 3'b000);
        @(negedge clock); chk("ab_gray1", gray, 3'b001);
        @(negedge clock); chk("ab_gray2", gray, 3'b011);
        req0 = 0;
        @(negedge clock);
        chk("ab_done", done, 1); chk("ab_flag", aborted, 1); chk("ab_gray_hold", gray, 3'b011);
        @(negedge clock); chk("ab_idle", busy, 0); chk("ab_flag_clr", aborted, 0);

        // Asynchronous reset mid-run
        req0 = 1; start0 = 3'b000; len0 = 4'd5;
        @(negedge clock);
        @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1; req0 = 0;
        #1;
        chk("ar_gray", gray, 0); chk("ar_gnt", {gnt1, gnt0}, 0); chk("ar_busy", busy, 0); chk("ar_done", done, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("ar_no_done", done, 0);
        end
        req1 = 1; start1 = 3'b010; len1 = 4'd1;
        @(negedge clock); chk("ar_gnt1", gnt1, 1); chk("ar_gray_ld", gray, 3'b010);
        @(negedge clock); chk("ar_gray_step", gray, 3'b110); chk("ar_done1", done, 1);
        req1 = 0;
        @(negedge clock);

        // Full cycle through all eight codes
        req0 = 1; start0 = 3'b000; len0 = 4'd8;
        wraps = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            chk($sformatf("fc_gray%0d", i), gray, full_seq[i]);
            wraps += int'(wrap);
        end
        chk("fc_done", done, 1);
        req0 = 0;
        @(negedge clock);
        wraps += int'(wrap);
        chk("fc_wrap_count", wraps, 1);

        // Randomized traffic against the model
        n_done = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            if (m_done) n_done++;
            if (!req0) begin
                if ($urandom % 3 == 0) begin
                    req0 = 1; start0 = W'($urandom);
                    len0 = ($urandom % 4 == 0) ? LEN_W'($urandom) : LEN_W'($urandom % 4);
                end
            end else if (m_done && m_gnt0) req0 = 0;
            else if (m_gnt0 && m_state == 1 && $urandom % 12 == 0) req0 = 0;
            if (!req1) begin
                if ($urandom % 3 == 0) begin
                    req1 = 1; start1 = W'($urandom);
                    len1 = ($urandom % 4 == 0) ? LEN_W'($urandom) : LEN_W'($urandom % 4);
                end
            end else if (m_done && m_gnt1) req1 = 0;
            else if (m_gnt1 && m_state == 1 && $urandom % 12 == 0) req1 = 0;
        end
        chk("rand_runs_completed", n_done > 20, 1);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
